// File: rtl/multi_button_pulse.sv
// N-channel button conditioner: debouncer with hysteresis, registered rising-edge
// strobe and a stretched pulse per channel, with optional retrigger.
module multi_button_pulse #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned DB_LEN       = 4,
  parameter int unsigned PULSE_CYCLES = 25_000_000,
  parameter int unsigned RETRIGGER    = 0
) (
  input  logic            sys_clk,
  input  logic            reset,
  input  logic [N_CH-1:0] in,
  output logic [N_CH-1:0] db_out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] pulse,
  output logic            any_pulse
);

  localparam int unsigned CNT_W = $clog2(PULSE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic {StIdle, StActive} state_e;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DB_LEN-1:0] q_q, q_d;
    logic              db_q, db_d;
    logic              rise_q, rise_d;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
      q_d     = {q_q[DB_LEN-2:0], in[i]};
      db_d    = db_q;
      state_d = state_q;
      cnt_d   = cnt_q;

      // Only a full run of equal samples moves the level; anything mixed holds it.
      if (&q_q) begin
        db_d = 1'b1;
      end else if (~|q_q) begin
        db_d = 1'b0;
      end
      rise_d = db_d & ~db_q;

      unique case (state_q)
        StIdle: begin
          if (rise_q) begin
            state_d = StActive;
            cnt_d   = CntOne;
          end
        end
        StActive: begin
          // A retrigger wins over the terminal count; otherwise a press here is dropped.
          if ((RETRIGGER != 0) && rise_q) begin
            cnt_d = CntOne;
          end else if (cnt_q == CntMax) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
      endcase
    end

    always_ff @(posedge sys_clk) begin
      if (reset) begin
        q_q     <= '0;
        db_q    <= 1'b0;
        rise_q  <= 1'b0;
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        q_q     <= q_d;
        db_q    <= db_d;
        rise_q  <= rise_d;
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign db_out[i] = db_q;
    assign rise[i]   = rise_q;
    assign pulse[i]  = (state_q == StActive);
  end

  assign any_pulse = |pulse;

endmodule

// File: tb/tb_multi_button_pulse.sv
// Directed bench for multi_button_pulse: two instances (RETRIGGER=0 and 1) share the
// same stimulus; per-window statistics are compared with hand-computed values.
module tb_multi_button_pulse;

  localparam int unsigned NCh = 2;

  logic           sys_clk;
  logic           reset;
  logic [NCh-1:0] in;
  logic [NCh-1:0] db_out0, rise0, pulse0;
  logic [NCh-1:0] db_out1, rise1, pulse1;
  logic           any_pulse0, any_pulse1;

  multi_button_pulse #(
    .N_CH(NCh), .DB_LEN(4), .PULSE_CYCLES(10), .RETRIGGER(0)
  ) u_dut0 (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .in       (in),
    .db_out   (db_out0),
    .rise     (rise0),
    .pulse    (pulse0),
    .any_pulse(any_pulse0)
  );

  multi_button_pulse #(
    .N_CH(NCh), .DB_LEN(4), .PULSE_CYCLES(10), .RETRIGGER(1)
  ) u_dut1 (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .in       (in),
    .db_out   (db_out1),
    .rise     (rise1),
    .pulse    (pulse1),
    .any_pulse(any_pulse1)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [NCh-1:0] stim [0:63];

  // Window statistics; edge numbers are 1-based within the window, 0 means never.
  int n_rise0, first_rise0, n_db0, n_fall, first_fall;
  int n_p0, first_p0, last_p0, n_p0r, last_p0r, n_p1, n_pm, n_ch1;
  int n_any, any_run, max_any_run;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stim();
    for (int k = 0; k < 64; k++) stim[k] = '0;
  endtask

  task automatic set_stim(input int lo, input int hi, input logic [NCh-1:0] v);
    for (int e = lo; e <= hi; e++) stim[e-1] = v;
  endtask

  task automatic run_win(input int n);
    logic prev_db;
    n_rise0 = 0; first_rise0 = 0; n_db0 = 0; n_fall = 0; first_fall = 0;
    n_p0 = 0; first_p0 = 0; last_p0 = 0; n_p0r = 0; last_p0r = 0;
    n_p1 = 0; n_pm = 0; n_ch1 = 0; n_any = 0; any_run = 0; max_any_run = 0;
    prev_db = db_out0[0];
    for (int e = 1; e <= n; e++) begin
      in = stim[e-1];
      tick();
      if (rise0[0]) begin
        n_rise0++;
        if (first_rise0 == 0) first_rise0 = e;
      end
      if (db_out0[0]) n_db0++;
      if (prev_db && !db_out0[0]) begin
        n_fall++;
        if (first_fall == 0) first_fall = e;
      end
      prev_db = db_out0[0];
      if (pulse0[0]) begin
        n_p0++;
        if (first_p0 == 0) first_p0 = e;
        last_p0 = e;
      end
      if (pulse1[0]) begin
        n_p0r++;
        last_p0r = e;
      end
      if (pulse0[1]) n_p1++;
      if (pulse0[0] != pulse0[1]) n_pm++;
      if (db_out0[1] | rise0[1] | pulse0[1]) n_ch1++;
      if (any_pulse0) begin
        n_any++;
        any_run++;
        if (any_run > max_any_run) max_any_run = any_run;
      end else begin
        any_run = 0;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    in    = '0;
    clear_stim();
    repeat (3) tick();
    chk("reset_state_rt0", int'({db_out0, rise0, pulse0, any_pulse0}), 0);
    chk("reset_state_rt1", int'({db_out1, rise1, pulse1, any_pulse1}), 0);
    reset = 1'b0;
    tick();

    // 1: clean press held 30 cycles on channel 0.
    clear_stim();
    set_stim(1, 30, 2'b01);
    run_win(40);
    chk("t1_first_rise", first_rise0, 5);
    chk("t1_rise_count", n_rise0, 1);
    chk("t1_pulse_first", first_p0, 6);
    chk("t1_pulse_last", last_p0, 15);
    chk("t1_pulse_len", n_p0, 10);
    chk("t1_pulse_len_rt1", n_p0r, 10);
    chk("t1_ch1_quiet", n_ch1, 0);
    chk("t1_db_high_cycles", n_db0, 30);
    chk("t1_fall_edge", first_fall, 35);

    // 2: bouncing press, then bouncing release.
    clear_stim();
    set_stim(1, 1, 2'b01); set_stim(2, 2, 2'b00); set_stim(3, 4, 2'b01);
    set_stim(5, 5, 2'b00); set_stim(6, 30, 2'b01);
    set_stim(32, 32, 2'b01);
    run_win(50);
    chk("t2_first_rise", first_rise0, 10);
    chk("t2_rise_count", n_rise0, 1);
    chk("t2_pulse_len", n_p0, 10);
    chk("t2_fall_count", n_fall, 1);
    chk("t2_fall_edge", first_fall, 37);
    chk("t2_db_high_cycles", n_db0, 27);

    // 3: single-cycle low glitch while debounced high and pulsing.
    clear_stim();
    set_stim(1, 8, 2'b01); set_stim(10, 25, 2'b01);
    run_win(40);
    chk("t3_rise_count", n_rise0, 1);
    chk("t3_db_high_cycles", n_db0, 25);
    chk("t3_fall_count", n_fall, 1);
    chk("t3_pulse_len", n_p0, 10);

    // 4a: fastest possible second debounced press; FSM sees it at count 8.
    clear_stim();
    set_stim(1, 4, 2'b01); set_stim(9, 12, 2'b01);
    run_win(40);
    chk("t4a_rise_count", n_rise0, 2);
    chk("t4a_pulse_len_rt0", n_p0, 10);
    chk("t4a_pulse_len_rt1", n_p0r, 18);
    chk("t4a_pulse_last_rt1", last_p0r, 23);

    // 4b: second press seen on the terminal-count cycle.
    clear_stim();
    set_stim(1, 4, 2'b01); set_stim(11, 14, 2'b01);
    run_win(40);
    chk("t4b_rise_count", n_rise0, 2);
    chk("t4b_pulse_len_rt0", n_p0, 10);
    chk("t4b_pulse_last_rt0", last_p0, 15);
    chk("t4b_pulse_len_rt1", n_p0r, 20);
    chk("t4b_pulse_last_rt1", last_p0r, 25);

    // 5: reset mid-pulse with the input held high counts as a fresh press afterwards.
    in = 2'b01;
    repeat (10) tick();
    chk("t5_pulse_before_reset", int'(pulse0[0]), 1);
    reset = 1'b1;
    tick();
    chk("t5_abort_rt0", int'({db_out0, rise0, pulse0, any_pulse0}), 0);
    chk("t5_abort_rt1", int'({db_out1, rise1, pulse1, any_pulse1}), 0);
    reset = 1'b0;
    clear_stim();
    set_stim(1, 30, 2'b01);
    run_win(40);
    chk("t5_first_rise", first_rise0, 5);
    chk("t5_pulse_first", first_p0, 6);
    chk("t5_pulse_len", n_p0, 10);

    // 6a: both channels pressed together.
    clear_stim();
    set_stim(1, 30, 2'b11);
    run_win(40);
    chk("t6a_pulse1_len", n_p1, 10);
    chk("t6a_pulse_diff", n_pm, 0);
    chk("t6a_any_len", n_any, 10);

    // 6b: channel 1 pressed 6 cycles after channel 0.
    clear_stim();
    set_stim(1, 6, 2'b01); set_stim(7, 30, 2'b11); set_stim(31, 36, 2'b10);
    run_win(50);
    chk("t6b_pulse0_len", n_p0, 10);
    chk("t6b_pulse1_len", n_p1, 10);
    chk("t6b_any_len", n_any, 16);
    chk("t6b_any_run", max_any_run, 16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
